// File: rtl/multi_channel_gather.sv
// Round-robin gather of NUM_CH show-ahead FIFOs into framed bursts.
// Frame: header, BURST_LEN payload words, optional XOR trailer.
// Ports: clk, rst_n, enable; ch_data/ch_level/ch_full in, ch_rdreq out;
// out_data/out_valid/out_sof/out_eof out, out_ready in;
// ovf_flags out, ovf_clear in; busy out.
// Optional macro: GATHER_CHECKSUM_EN adds the XOR trailer word.
module multi_channel_gather #(
  parameter int NUM_CH    = 6,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int LVL_W     = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*LVL_W-1:0]  ch_level,
  input  logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_rdreq,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [NUM_CH-1:0]        ovf_flags,
  input  logic [NUM_CH-1:0]        ovf_clear,
  output logic                     busy
);

  localparam logic [LVL_W-1:0] THR =
    LVL_W'(BURST_LEN);
  localparam logic [7:0] BLEN8 =
    8'(BURST_LEN);
  localparam logic [7:0] LAST =
    8'(BURST_LEN - 1);

`ifdef GATHER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_TRL
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY
  } state_t;
`endif

  state_t state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] rr_q, rr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
`ifdef GATHER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic [31:0] elig_c;
  logic [4:0] scan_c;
  logic [3:0] pick_c;
  logic found_c;
  logic [DATA_W-1:0] pay_c;
  logic last_c;

  // Padded to 32 so a 5-bit scan index always fits.
  always_comb begin
    elig_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig_c[i] =
        ch_level[i*LVL_W +: LVL_W] >= THR;
    end
  end

  // First eligible channel at or after rr_q,
  // wrapping past NUM_CH-1 back to 0.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    scan_c  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_c = 5'(rr_q) + 5'(k);
      if (scan_c >= 5'(NUM_CH)) begin
        scan_c = scan_c - 5'(NUM_CH);
      end
      if (!found_c && elig_c[scan_c]) begin
        found_c = 1'b1;
        pick_c  = scan_c[3:0];
      end
    end
  end

  always_comb begin
    pay_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == 4'(i)) begin
        pay_c = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign last_c = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
`ifdef GATHER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable && found_c) begin
          grant_d = pick_c;
          if (pick_c == 4'(NUM_CH - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = pick_c + 4'd1;
          end
          hdr_d = '0;
          hdr_d[15:0] = {4'hA, pick_c, BLEN8};
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (out_ready) begin
          cnt_d   = '0;
`ifdef GATHER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (out_ready) begin
          cnt_d  = cnt_q + 8'd1;
`ifdef GATHER_CHECKSUM_EN
          csum_d = csum_q ^ pay_c;
`endif
          if (last_c) begin
            cnt_d = '0;
`ifdef GATHER_CHECKSUM_EN
            state_d = S_TRL;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef GATHER_CHECKSUM_EN
      S_TRL: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Set wins over clear in the same cycle.
  assign ovf_d = (ovf_q & ~ovf_clear) | ch_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      ovf_q   <= '0;
`ifdef GATHER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      ovf_q   <= ovf_d;
`ifdef GATHER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q != S_IDLE);
    busy      = (state_q != S_IDLE);
    out_sof   = (state_q == S_HDR);
    out_data  = '0;
    out_eof   = 1'b0;
    ch_rdreq  = '0;
    unique case (1'b1)
      (state_q == S_HDR): begin
        out_data = hdr_q;
      end
      (state_q == S_PAY): begin
        out_data = pay_c;
`ifndef GATHER_CHECKSUM_EN
        out_eof  = last_c;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
          ch_rdreq[i] =
            out_ready && (grant_q == 4'(i));
        end
      end
`ifdef GATHER_CHECKSUM_EN
      (state_q == S_TRL): begin
        out_data = csum_q;
        out_eof  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_multi_channel_gather.sv
// Directed bench for multi_channel_gather.
// Models six show-ahead FIFOs and checks framing, arbitration, flags.
module tb_multi_channel_gather;

  localparam int NCH = 6;
`ifdef GATHER_CHECKSUM_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic clk = 0;
  logic rst_n;
  logic enable;
  logic [NCH*16-1:0] ch_data;
  logic [NCH*9-1:0] ch_level;
  logic [NCH-1:0] ch_full;
  logic [NCH-1:0] ch_rdreq;
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eof;
  logic [NCH-1:0] ovf_flags;
  logic [NCH-1:0] ovf_clear;
  logic busy;

  multi_channel_gather dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch_data(ch_data), .ch_level(ch_level),
    .ch_full(ch_full), .ch_rdreq(ch_rdreq),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof),
    .out_eof(out_eof), .ovf_flags(ovf_flags),
    .ovf_clear(ovf_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  int lvl[NCH];
  int pcnt[NCH];
  logic [15:0] base[NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_data[i*16 +: 16] = base[i] + 16'(pcnt[i]);
      ch_level[i*9 +: 9] = 9'(lvl[i]);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  logic o_valid, o_sof, o_eof, o_busy, o_rdy;
  logic [15:0] o_data;
  logic [NCH-1:0] o_rd, o_ovf;

  // Sample on the falling edge, apply FIFO pops just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    o_valid = out_valid; o_sof = out_sof;
    o_eof = out_eof; o_busy = busy;
    o_rdy = out_ready; o_data = out_data;
    o_rd = ch_rdreq; o_ovf = ovf_flags;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (o_rd[i]) begin
        lvl[i]--;
        pcnt[i]++;
      end
    end
  endtask

  int f_gap, f_len, f_eofpos;
  int f_hold_bad, f_rdlow_bad, f_sof_bad;
  bit f_timeout, f_sof0;
  int f_pops[NCH];
  logic [15:0] f_w[16];

  task automatic grab(input bit tog);
    logic [15:0] held;
    bit hp;
    hp = 0; held = '0;
    f_gap = 0; f_len = 0; f_eofpos = -1;
    f_hold_bad = 0; f_rdlow_bad = 0;
    f_sof_bad = 0; f_timeout = 0; f_sof0 = 0;
    for (int i = 0; i < NCH; i++) f_pops[i] = 0;
    out_ready = 1'b1;
    cyc();
    while (!o_valid) begin
      f_gap++;
      if (f_gap > 50) begin
        f_timeout = 1;
        return;
      end
      cyc();
    end
    forever begin
      if (hp && o_data !== held) f_hold_bad++;
      hp = 0;
      for (int i = 0; i < NCH; i++)
        f_pops[i] += int'(o_rd[i]);
      if (!o_rdy && o_rd != '0) f_rdlow_bad++;
      if (o_rdy) begin
        if (f_len == 0) f_sof0 = o_sof;
        else if (o_sof) f_sof_bad++;
        f_w[f_len] = o_data;
        if (o_eof) begin
          f_eofpos = f_len;
          f_len++;
          break;
        end
        f_len++;
        if (f_len > 15) begin
          f_timeout = 1;
          break;
        end
      end else begin
        held = o_data;
        hp = 1;
      end
      out_ready = tog ? ~out_ready : 1'b1;
      cyc();
    end
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int i = 0; i < NCH; i++) begin
      lvl[i] = 0; pcnt[i] = 0; base[i] = '0;
    end
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; out_ready = 0;
    ch_full = '0; ovf_clear = '0;
    for (int i = 0; i < NCH; i++) begin
      lvl[i] = 0; pcnt[i] = 0; base[i] = '0;
    end
    cyc(); cyc();
    n_chk++;
    if ({o_valid, o_sof, o_eof, o_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got v%b s%b e%b b%b want 0",
               o_valid, o_sof, o_eof, o_busy);
    end
    n_chk++;
    if ({o_rd, o_ovf, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data rd=%h ovf=%h data=%h want 0",
               o_rd, o_ovf, o_data);
    end
    rst_n = 1; enable = 1; out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_chk++;
      if ({o_valid, o_busy, o_rd} !== '0) begin
        n_fail++;
        $display("FAIL idle_empty c=%0d v=%b b=%b rd=%h want 0",
                 c, o_valid, o_busy, o_rd);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] x;
    base[2] = 16'h0100; lvl[2] = 8;
    grab(0);
    n_chk++;
    if (f_timeout || f_gap != 1) begin
      n_fail++;
      $display("FAIL single_latency gap=%0d to=%0d want 1",
               f_gap, f_timeout);
    end
    n_chk++;
    if (f_w[0] !== 16'hA208 || !f_sof0) begin
      n_fail++;
      $display("FAIL single_hdr got %h sof=%b want a208 sof=1",
               f_w[0], f_sof0);
    end
    x = '0;
    for (int k = 0; k < 8; k++) begin
      x ^= 16'h0100 + 16'(k);
      n_chk++;
      if (f_w[1+k] !== 16'h0100 + 16'(k)) begin
        n_fail++;
        $display("FAIL single_pay k=%0d got %h want %h",
                 k, f_w[1+k], 16'h0100 + 16'(k));
      end
    end
`ifdef GATHER_CHECKSUM_EN
    n_chk++;
    if (f_w[9] !== x) begin
      n_fail++;
      $display("FAIL single_trl got %h want %h", f_w[9], x);
    end
`endif
    n_chk++;
    if (f_len != FLEN || f_eofpos != FLEN - 1
        || f_sof_bad != 0) begin
      n_fail++;
      $display("FAIL single_frame len=%0d eof@%0d sofbad=%0d want %0d",
               f_len, f_eofpos, f_sof_bad, FLEN);
    end
    n_chk++;
    if (f_pops[2] != 8 || f_pops[0] + f_pops[1] + f_pops[3]
        + f_pops[4] + f_pops[5] != 0) begin
      n_fail++;
      $display("FAIL single_pops ch2=%0d want 8 others 0", f_pops[2]);
    end
  endtask

  task automatic test_rr();
    int g[4];
    g = '{0, 3, 5, 0};
    do_reset();
    base[0] = 16'h1000; base[3] = 16'h3000;
    base[5] = 16'h5000;
    lvl[0] = 16; lvl[3] = 8; lvl[5] = 8;
    for (int f = 0; f < 4; f++) begin
      grab(0);
      n_chk++;
      if (f_timeout || f_gap != 1) begin
        n_fail++;
        $display("FAIL rr_gap f=%0d gap=%0d to=%0d want 1",
                 f, f_gap, f_timeout);
      end
      n_chk++;
      if (f_w[0] !== (16'hA008 | 16'(g[f] << 8))) begin
        n_fail++;
        $display("FAIL rr_grant f=%0d got %h want ch %0d",
                 f, f_w[0], g[f]);
      end
      n_chk++;
      if (f_w[8] !== base[g[f]] + 16'(f == 3 ? 15 : 7)
          || f_pops[g[f]] != 8) begin
        n_fail++;
        $display("FAIL rr_pay f=%0d last=%h pops=%0d",
                 f, f_w[8], f_pops[g[f]]);
      end
    end
  endtask

  task automatic test_backpressure();
    base[1] = 16'h2000; lvl[1] = 8;
    grab(1);
    n_chk++;
    if (f_timeout || f_w[0] !== 16'hA108) begin
      n_fail++;
      $display("FAIL bp_hdr got %h to=%0d want a108", f_w[0], f_timeout);
    end
    n_chk++;
    if (f_hold_bad != 0 || f_rdlow_bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold holdbad=%0d rdlow=%0d want 0",
               f_hold_bad, f_rdlow_bad);
    end
    n_chk++;
    if (f_pops[1] != 8 || f_w[1] !== 16'h2000
        || f_w[8] !== 16'h2007 || f_len != FLEN) begin
      n_fail++;
      $display("FAIL bp_pay pops=%0d w1=%h w8=%h len=%0d",
               f_pops[1], f_w[1], f_w[8], f_len);
    end
  endtask

  task automatic test_enable();
    int p, nv;
    bit seen;
    base[4] = 16'h4000; lvl[4] = 16;
    enable = 1; out_ready = 1;
    cyc(); cyc();
    n_chk++;
    if (!o_sof || o_data !== 16'hA408) begin
      n_fail++;
      $display("FAIL en_hdr sof=%b data=%h want 1 a408", o_sof, o_data);
    end
    enable = 0;
    p = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      p += int'(o_rd[4]);
      seen = o_eof;
    end
    n_chk++;
    if (!seen || p != 8) begin
      n_fail++;
      $display("FAIL en_drain eof=%b pops=%0d want 1 8", seen, p);
    end
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      cyc();
      nv += int'(o_valid);
    end
    n_chk++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL en_hold valid_cycles=%0d want 0", nv);
    end
    enable = 1;
    grab(0);
    n_chk++;
    if (f_timeout || f_gap != 1 || f_w[0] !== 16'hA408) begin
      n_fail++;
      $display("FAIL en_resume gap=%0d hdr=%h want 1 a408",
               f_gap, f_w[0]);
    end
  endtask

  task automatic test_ovf();
    ch_full = 6'b010000;
    cyc();
    ch_full = '0;
    cyc();
    n_chk++;
    if (o_ovf !== 6'b010000) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 010000", o_ovf);
    end
    cyc(); cyc(); cyc();
    n_chk++;
    if (o_ovf !== 6'b010000) begin
      n_fail++;
      $display("FAIL ovf_sticky got %b want 010000", o_ovf);
    end
    ovf_clear = 6'b010000;
    cyc();
    ovf_clear = '0;
    cyc();
    n_chk++;
    if (o_ovf !== 6'b000000) begin
      n_fail++;
      $display("FAIL ovf_clear got %b want 000000", o_ovf);
    end
    ch_full = 6'b010010;
    cyc();
    ch_full = '0;
    ovf_clear = 6'b000010;
    cyc();
    ovf_clear = '0;
    ch_full = 6'b010000;
    ovf_clear = 6'b010000;
    cyc();
    ch_full = '0;
    ovf_clear = '0;
    cyc();
    n_chk++;
    if (o_ovf !== 6'b010000) begin
      n_fail++;
      $display("FAIL ovf_setwins got %b want 010000", o_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    base[0] = 16'h7000; lvl[0] = 8; pcnt[0] = 0;
    enable = 1; out_ready = 1;
    cyc(); cyc(); cyc();
    n_chk++;
    if (o_rd !== 6'b000001 || o_data !== 16'h7000) begin
      n_fail++;
      $display("FAIL mid_pay rd=%b data=%h want 000001 7000",
               o_rd, o_data);
    end
    rst_n = 0;
    cyc();
    n_chk++;
    if ({o_valid, o_sof, o_eof, o_busy} !== 4'b0
        || {o_rd, o_ovf, o_data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset v%b s%b e%b b%b rd=%h ovf=%h d=%h want 0",
               o_valid, o_sof, o_eof, o_busy, o_rd, o_ovf, o_data);
    end
    rst_n = 1;
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      nv += int'(o_valid);
    end
    n_chk++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL mid_after valid_cycles=%0d want 0", nv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_enable();
    test_ovf();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_gather.md
Name: multi_channel_gather

Overview:
- Parametrised successor to the three-channel gather stage between the per-channel AD acquisition FIFOs and the communication FPGA link.
- Serves NUM_CH show-ahead channel FIFOs round-robin and emits fixed-length framed bursts on one DATA_W-bit valid/ready stream: header, payload, optional checksum trailer.
- Adds per-channel sticky overflow capture and a graceful enable/drain control.

Parameters:
- NUM_CH, 6, number of channel FIFOs served (2..16).
- DATA_W, 16, word width of channel data and output stream (>=16).
- BURST_LEN, 8, payload words per frame (1..255).
- LVL_W, 9, width of each channel's FIFO fill-level input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = start new frames; 0 = finish current frame, then hold IDLE.
- ch_data  input  NUM_CH*DATA_W  packed show-ahead FIFO data; channel i at [i*DATA_W +: DATA_W].
- ch_level  input  NUM_CH*LVL_W  packed FIFO fill levels.
- ch_full  input  NUM_CH  per-channel FIFO full flags.
- ch_rdreq  output  NUM_CH  per-channel pop strobes, one-hot or zero.
- out_data  output  DATA_W  stream word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- out_sof  output  1  high with the header word.
- out_eof  output  1  high with the last word of the frame.
- ovf_flags  output  NUM_CH  sticky overflow flags.
- ovf_clear  input  NUM_CH  clear mask for ovf_flags.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: ch_rdreq=0, out_valid=0, out_data=0, out_sof=0, out_eof=0, ovf_flags=0, busy=0; FSM=IDLE, rr_ptr=0, word counter=0, checksum=0.
- Eligibility: channel i is eligible when ch_level[i] >= BURST_LEN.
- IDLE: if enable=1 and any channel is eligible, latch grant = first eligible index scanning upward from rr_ptr, wrapping NUM_CH-1 -> 0. Set rr_ptr = grant+1 (mod NUM_CH) and go to HEADER.
- Latency: eligibility seen in IDLE at cycle N gives header out_valid at cycle N+1.
- HEADER: registered out_data = {4'hA, grant[3:0], BURST_LEN[7:0]}, zero-padded in the upper bits when DATA_W>16. out_valid=1, out_sof=1. Hold all outputs stable until accepted, then go to PAYLOAD with counter=0.
- PAYLOAD: out_data = granted channel's ch_data (combinational mux); out_valid=1.
  - ch_rdreq[grant] = out_ready; the word is popped in the same cycle it is accepted.
  - Counter increments on each accept.
  - out_eof=1 on word BURST_LEN-1 when the trailer is compiled out.
  - After BURST_LEN accepts, go to TRAILER (feature on) or IDLE.
- Backpressure: while out_ready=0, ch_rdreq stays 0 and out_data/out_sof/out_eof hold.
- A frame, once started, always completes regardless of enable and of other channels' state. The eligibility threshold guarantees the granted FIFO cannot underflow.
- rr_ptr wraps from NUM_CH-1 to 0. A single busy channel is granted back-to-back frames with one IDLE cycle between them.
- Overflow flags:
  - ovf_flags[i] sets on any cycle with ch_full[i]=1.
  - ovf_clear[i] clears the flag; if set and clear occur in the same cycle, set wins.
  - Flags update in every state.
- Reset asserted mid-frame aborts immediately to reset values. A partial frame is not completed; the downstream resynchronises on out_sof.

Optional Feature:
- Macro: GATHER_CHECKSUM_EN.
- Defined: TRAILER state follows PAYLOAD. Trailer out_data = XOR of the BURST_LEN payload words. The checksum register clears on header accept and accumulates on each payload accept. out_eof=1 on the trailer only. Frame length is BURST_LEN+2.
- Undefined: no TRAILER state or checksum logic. out_eof is on the last payload word. Frame length is BURST_LEN+1.

Test Plan:
- Reset, then all ch_level=0 and enable=1 for 20 cycles -> out_valid=0, busy=0, ch_rdreq=0 throughout.
- Channel 2 at level 8, out_ready=1, payload 0x0100..0x0107 -> header 0xA208 with out_sof. Then 8 words with ch_rdreq[2] pulsed 8 times and out_eof on 0x0107; trailer 0x0000 when the feature is on.
- Channels 0, 3, 5 all at level >= 8 -> grant order 0, 3, 5, 0. Exactly one IDLE cycle between frames.
- out_ready toggled 1-0 each cycle during PAYLOAD -> out_data held while ready=0, no pop while ready=0, exactly 8 pops total.
- enable dropped after header accept -> current frame completes; no new header while enable=0 even with eligible channels.
- ch_full[4] pulsed for 1 cycle -> ovf_flags[4]=1 until ovf_clear[4]. ch_full and ovf_clear asserted in the same cycle -> flag stays 1. rst_n pulsed mid-payload -> all outputs 0 on the next cycle.
